// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one combinational ALU between two requesters. It grants round-robin
//   and allows one operation in flight. Operands, opcode and result are all
//   registered. An operation moves IDLE -> EXEC -> RESP -> IDLE. The ALU itself
//   lives outside this block: it sees alu_a/alu_b/alu_op and returns alu_res in
//   the same cycle.
//
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready    request handshake, requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op    request operands and ALU opcode
//   alu_a, alu_b, alu_op       registered operands/opcode driven to the ALU
//   alu_res                    ALU result, combinational from alu_a/b/op
//   respN_valid / respN_ready  response handshake, requester N
//   respN_data                 result for requester N (0 when N is not owner)
//   busy                       high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN = 64,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] alu_res,

    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_data,

    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_data,

    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e          state_q,  state_d;
    logic            prio_q,   prio_d;
    logic            owner_q,  owner_d;
    logic [XLEN-1:0] alu_a_q,  alu_a_d;
    logic [XLEN-1:0] alu_b_q,  alu_b_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [XLEN-1:0] result_q, result_d;

    logic grant_sel;    // 0 -> requester 0, 1 -> requester 1
    logic accept;       // a request is taken at the next edge
    logic owner_ready;  // the current owner takes its response

    // A lone valid wins outright. When both are valid, the priority bit decides.
    assign grant_sel   = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign accept      = (state_q == S_IDLE) && (req0_valid || req1_valid);
    assign owner_ready = owner_q ? resp1_ready : resp0_ready;

    always_comb begin
        // NOTE: every signal gets its hold value before the case. No path can
        // then leave one unassigned, so no latch is inferred.
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d  = grant_sel ? req1_a  : req0_a;
                    alu_b_d  = grant_sel ? req1_b  : req0_b;
                    alu_op_d = grant_sel ? req1_op : req0_op;
                    owner_d  = grant_sel;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                // The operands have been stable on the ALU for this cycle.
                result_d = alu_res;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (owner_ready) begin
                    // The requester just served yields priority to the other one.
                    prio_d  = ~owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop then
    // samples its pre-edge value, with no ordering race between blocks.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            result_q <= result_d;
        end
    end

    // The state is IDLE during reset. Gating with rstn keeps both readies low
    // while reset is held, even if requesters are asserting valid.
    assign req0_ready = rstn && accept && !grant_sel;
    assign req1_ready = rstn && accept &&  grant_sel;

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;

    assign resp0_valid = (state_q == S_RESP) && !owner_q;
    assign resp1_valid = (state_q == S_RESP) &&  owner_q;
    assign resp0_data  = resp0_valid ? result_q : '0;
    assign resp1_data  = resp1_valid ? result_q : '0;

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [63:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [63:0] resp0_data, resp1_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(64), .OPW(4)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .busy(busy)
    );

    // External ALU. Opcode map: ADD SUB SLL SLT SLTU XOR SRL OR AND SRA ADDW SUBW SLLW SRLW SRAW, then undefined.
    function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
        logic [31:0] w;
        w = 32'd0;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[5:0];
            4'd3:  return {63'd0, ($signed(a) < $signed(b))};
            4'd4:  return {63'd0, (a < b)};
            4'd5:  return a ^ b;
            4'd6:  return a >> b[5:0];
            4'd7:  return a | b;
            4'd8:  return a & b;
            4'd9:  return $signed(a) >>> b[5:0];
            4'd10: w = a[31:0] + b[31:0];
            4'd11: w = a[31:0] - b[31:0];
            4'd12: w = a[31:0] << b[4:0];
            4'd13: w = a[31:0] >> b[4:0];
            4'd14: w = $signed(a[31:0]) >>> b[4:0];
            default: return 64'd0;
        endcase
        return {{32{w[31]}}, w};
    endfunction

    assign alu_res = alu_model(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Compares the live response against the oldest scoreboard entry.
    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check("resp_port",        64'(resp1_valid), 64'(e.port));
        check("resp_data",        e.port ? resp1_data : resp0_data, e.data);
        check("resp_other_valid", 64'(e.port ? resp0_valid : resp1_valid), 64'd0);
        check("resp_other_data",  e.port ? resp0_data : resp1_data, 64'd0);
    endtask

    // Waits at falling edges for a response and returns how many edges it took.
    task automatic get_resp(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(resp0_valid || resp1_valid) && waited < budget);
        if (resp0_valid || resp1_valid) pop_check();
        else check("resp_timeout", 64'(resp0_valid | resp1_valid), 64'd1);
    endtask

    // Runs one op from a single requester. Call at a falling edge in IDLE, with the response ready high.
    task automatic run_op(input logic n, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] op, input logic [63:0] exp);
        int w;
        if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        #1;
        check("op_grant", 64'(n ? req1_ready : req0_ready), 64'd1);
        sb_q.push_back('{n, exp});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("op_busy_exec", 64'(busy), 64'd1);
        get_resp(8, w);
        check("op_latency", 64'(w), 64'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        logic g;

        // Reset state.
        do_reset();
        #1;
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_alu_a",  alu_a, 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_rvalid", 64'(resp0_valid | resp1_valid), 64'd0);
        check("rst_rdata",  resp0_data | resp1_data, 64'd0);

        // 1: single ADD on requester 0, with the exact cycle timing.
        req0_valid = 1'b1; req0_a = 64'd5; req0_b = 64'd7; req0_op = 4'b0000;
        #1;
        check("t1_ready0_T", 64'(req0_ready), 64'd1);
        check("t1_ready1_T", 64'(req1_ready), 64'd0);
        check("t1_busy_T",   64'(busy), 64'd0);
        sb_q.push_back('{1'b0, 64'd12});
        @(negedge clk);
        req0_valid = 1'b0;
        check("t1_busy_T1",  64'(busy), 64'd1);
        check("t1_ready_T1", 64'(req0_ready), 64'd0);
        check("t1_alu_a",    alu_a, 64'd5);
        check("t1_alu_b",    alu_b, 64'd7);
        get_resp(8, w);
        check("t1_latency",  64'(w), 64'd1);
        check("t1_busy_T2",  64'(busy), 64'd1);
        @(negedge clk);
        check("t1_idle_busy",   64'(busy), 64'd0);
        check("t1_idle_rvalid", 64'(resp0_valid), 64'd0);
        check("t1_alu_hold",    alu_a, 64'd5);

        // 2: both requesters valid continuously -> grants 0,1,0,1 from reset.
        do_reset();
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd1; req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 64'd9; req1_b = 64'd4; req1_op = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            g = i[0];
            check("t2_ready0", 64'(req0_ready), 64'(!g));
            check("t2_ready1", 64'(req1_ready), 64'(g));
            sb_q.push_back('{g, g ? 64'd5 : 64'd2});
            get_resp(8, w);
            check("t2_latency", 64'(w), 64'd2);
            @(negedge clk);
        end

        // 3: requester 0 stalls its response for 5 cycles. Then requester 1 is granted.
        resp0_ready = 1'b0;
        #1;
        check("t3_grant0", 64'(req0_ready), 64'd1);
        sb_q.push_back('{1'b0, 64'd2});
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid",  64'(resp0_valid), 64'd1);
            check("t3_hold_data",   resp0_data, 64'd2);
            check("t3_hold_ready",  64'(req0_ready | req1_ready), 64'd0);
            @(negedge clk);
        end
        pop_check();
        resp0_ready = 1'b1;
        @(negedge clk);
        #1;
        check("t3_next_ready1", 64'(req1_ready), 64'd1);
        check("t3_next_ready0", 64'(req0_ready), 64'd0);
        sb_q.push_back('{1'b1, 64'd5});
        get_resp(8, w);
        check("t3_latency", 64'(w), 64'd2);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // 4: word add sign extension, then arithmetic shift right.
        run_op(1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 4'b1010, 64'hFFFF_FFFF_8000_0000);
        run_op(1'b1, 64'h8000_0000_0000_0000, 64'd4, 4'b1001, 64'hF800_0000_0000_0000);

        // 5: reset during EXEC. The op is dropped and priority returns to requester 0.
        run_op(1'b0, 64'd10, 64'd20, 4'b0000, 64'd30);
        req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd2; req1_op = 4'b0000;
        #1;
        check("t5_grant1", 64'(req1_ready), 64'd1);
        @(negedge clk);
        check("t5_in_exec", 64'(busy), 64'd1);
        rstn = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd6; req0_b = 64'd7; req0_op = 4'b0000;
        #1;
        check("t5_rst_busy",   64'(busy), 64'd0);
        check("t5_rst_alu_a",  alu_a, 64'd0);
        check("t5_rst_alu_b",  alu_b, 64'd0);
        check("t5_rst_alu_op", 64'(alu_op), 64'd0);
        check("t5_rst_rvalid", 64'(resp0_valid | resp1_valid), 64'd0);
        check("t5_rst_rdata",  resp0_data | resp1_data, 64'd0);
        check("t5_rst_ready",  64'(req0_ready | req1_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("t5_after_ready0", 64'(req0_ready), 64'd1);
        check("t5_after_ready1", 64'(req1_ready), 64'd0);
        sb_q.push_back('{1'b0, 64'd13});
        get_resp(8, w);
        check("t5_latency", 64'(w), 64'd2);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_stale", 64'({resp0_valid, resp1_valid, busy}), 64'd0);
        end

        // 6: undefined opcode completes with 0, and priority moves to requester 1.
        run_op(1'b1, 64'd2, 64'd2, 4'b0000, 64'd4);
        run_op(1'b0, 64'd3, 64'd3, 4'b1111, 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t6_prio_ready1", 64'(req1_ready), 64'd1);
        check("t6_prio_ready0", 64'(req0_ready), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t6_sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
